lsu_ctrl: RTL and testbench
===========================

Name: lsu_ctrl

Overview:
Load/store sequencer between the MEM pipeline stage and the data-side memory bus (req/addr_ok/data_ok handshake). Accepts one memory op per transaction and checks alignment. Generates size, byte strobes and replicated write data. Waits for the bus, then aligns and sign/zero-extends load data, and stalls the pipeline until the op completes.

Parameters:
ADDR_WIDTH, 32, width of mem_addr/data_addr (byte address).

Ports:
clk  input  1  core clock
rst  input  1  asynchronous reset, active-high
mem_valid  input  1  MEM stage presents an op; held with all mem_* inputs stable until mem_ready
mem_op  input  4  op code (package LSU_* constants)
mem_addr  input  ADDR_WIDTH  effective byte address
mem_wdata  input  32  store source register value
flush  input  1  pipeline flush
mem_ready  output  1  op complete this cycle
mem_rdata  output  32  extended load result (0 for stores/ALE)
mem_ale  output  1  misaligned-address exception, valid with mem_ready
mem_stall  output  1  mem_valid & ~mem_ready
data_req  output  1  bus request
data_wr  output  1  1 = store
data_size  output  2  0 byte, 1 half, 2 word
data_addr  output  ADDR_WIDTH  byte address
data_wstrb  output  4  byte enables (0 on loads)
data_wdata  output  32  replicated store data
data_addr_ok  input  1  address phase accepted
data_data_ok  input  1  data phase complete
data_rdata  input  32  raw word read

Behaviour:
- Reset: state IDLE; all outputs 0; captured op/addr/wdata/result registers 0.
- Ops: NOP 0, LB 1, LBU 2, LH 3, LHU 4, LW 5, SB 6, SH 7, SW 8; codes 9-15 are treated as NOP.
- FSM states: IDLE, REQ, WAIT, DONE, DRAIN.
- IDLE: if mem_valid & ~flush & op≠NOP, capture op/addr/wdata.
  - If misaligned (half with addr[0]=1; word with addr[1:0]≠0): go to DONE with ale_q=1, result 0, no bus activity.
  - Otherwise go to REQ.
  - mem_valid with NOP: mem_ready=1 combinationally in IDLE, no state change.
- REQ: data_req=1, bus outputs driven from captured registers and stable. On addr_ok go to WAIT.
- WAIT: data_req=0. On data_ok capture the extended result (0 for stores) and go to DONE. data_ok is only honoured in WAIT/DRAIN; it never arrives in the same cycle as the addr_ok of the same request.
- DONE: mem_ready=1, mem_rdata=result_q, mem_ale=ale_q for exactly one cycle, then IDLE. A new op is accepted in IDLE the following cycle.
- Minimum latency: accept T, req/addr_ok T+1, data_ok T+2, mem_ready T+3. Each extra bus wait cycle adds one cycle.
- Store encoding (o = addr[1:0]):
  - SB: size 0, wstrb 4'b0001<<o, wdata {4{wdata[7:0]}}.
  - SH: size 1, wstrb 4'b0011<<o, wdata {2{wdata[15:0]}}.
  - SW: size 2, wstrb 4'hF, wdata as-is.
- Load extraction: r = data_rdata >> (8*o).
  - LB: sign-extend r[7:0]. LBU: zero-extend r[7:0].
  - LH: sign-extend r[15:0]. LHU: zero-extend r[15:0].
  - LW: r.
- Flush (priority over everything):
  - IDLE: op not accepted.
  - REQ without addr_ok: go to IDLE; data_req low next cycle.
  - REQ with addr_ok same cycle: go to DRAIN.
  - WAIT: go to DRAIN; if data_ok in the same cycle, go to IDLE instead.
  - DONE: go to IDLE with mem_ready/mem_ale forced 0.
- DRAIN: data_req=0, mem_ready=0. Wait for data_ok and discard the data, then go to IDLE. flush is ignored in DRAIN.
- A store is committed once addr_ok is seen; the pipeline never flushes an issued store (architectural rule, not checked here).
- Reset mid-transaction: immediate return to IDLE, outputs 0; the bus side is reset together with the controller.

Decomposition:
- Shared package/defines header holds: LSU_* op codes, state encodings, SIZE_B/H/W constants.
- One natural sub-module: lsu_load_align, a purely combinational block (raw word, offset, op → 32-bit extended result).
- Strobe/wdata generation stays inline.

Test Plan:
- LB addr 0x103, rdata 0x80FF_1234, addr_ok at T+1, data_ok at T+2 → mem_ready at T+3, mem_rdata 0xFFFF_FF80, mem_stall high T..T+2.
- LHU addr 0x102, rdata 0x8001_0000 → 0x0000_8001. LH same data → 0xFFFF_8001. LW addr 0x100 → raw word.
- SH addr 0x202, wdata 0xDEAD_BEEF → data_wr 1, size 1, wstrb 4'b1100, wdata 0xBEEF_BEEF; mem_ready after data_ok, mem_rdata 0.
- LW addr 0x101 → no data_req ever, mem_ready and mem_ale high at T+1, mem_rdata 0.
- addr_ok held low 3 cycles → data_req held, data_addr/wstrb stable; flush in 2nd REQ cycle → IDLE, no further req.
- Flush in WAIT, data_ok 2 cycles later with 0x1234_5678 → DRAIN, data discarded, mem_ready never pulses, next LW completes normally.

Source files
------------

// File: rtl/lsu_ctrl_pkg.sv
// Shared definitions for the load/store sequencer: op codes, FSM states,
// bus access sizes and small op-decoding helpers.
package lsu_ctrl_pkg;

    localparam logic [3:0] LSU_NOP = 4'd0;
    localparam logic [3:0] LSU_LB  = 4'd1;
    localparam logic [3:0] LSU_LBU = 4'd2;
    localparam logic [3:0] LSU_LH  = 4'd3;
    localparam logic [3:0] LSU_LHU = 4'd4;
    localparam logic [3:0] LSU_LW  = 4'd5;
    localparam logic [3:0] LSU_SB  = 4'd6;
    localparam logic [3:0] LSU_SH  = 4'd7;
    localparam logic [3:0] LSU_SW  = 4'd8;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_DONE,
        ST_DRAIN
    } lsu_state_e;

    // Codes above SW are reserved and behave exactly like NOP.
    function automatic logic op_is_nop(input logic [3:0] op);
        return (op == LSU_NOP) || (op > LSU_SW);
    endfunction

    function automatic logic op_is_store(input logic [3:0] op);
        return (op == LSU_SB) || (op == LSU_SH) || (op == LSU_SW);
    endfunction

    function automatic logic [1:0] op_size(input logic [3:0] op);
        logic [1:0] size;
        case (op)
            LSU_LH, LSU_LHU, LSU_SH: size = SIZE_H;
            LSU_LW, LSU_SW:          size = SIZE_W;
            default:                 size = SIZE_B;
        endcase
        return size;
    endfunction

    function automatic logic op_misaligned(input logic [3:0] op, input logic [1:0] off);
        logic bad;
        case (op_size(op))
            SIZE_H:  bad = off[0];
            SIZE_W:  bad = (off != 2'b00);
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// Data-side memory bus: request/address phase (addr_ok) followed by a
// separate data phase (data_ok).
interface lsu_ctrl_if #(
    parameter int ADDR_WIDTH = 32
) ();

    logic                  data_req;
    logic                  data_wr;
    logic [1:0]            data_size;
    logic [ADDR_WIDTH-1:0] data_addr;
    logic [3:0]            data_wstrb;
    logic [31:0]           data_wdata;
    logic                  data_addr_ok;
    logic                  data_data_ok;
    logic [31:0]           data_rdata;

    modport master (
        output data_req,
        output data_wr,
        output data_size,
        output data_addr,
        output data_wstrb,
        output data_wdata,
        input  data_addr_ok,
        input  data_data_ok,
        input  data_rdata
    );

    modport slave (
        input  data_req,
        input  data_wr,
        input  data_size,
        input  data_addr,
        input  data_wstrb,
        input  data_wdata,
        output data_addr_ok,
        output data_data_ok,
        output data_rdata
    );

endinterface

// File: rtl/lsu_load_align.sv
// Combinational load formatter: selects the addressed byte/half of the raw
// bus word and sign- or zero-extends it according to the load op.
module lsu_load_align
    import lsu_ctrl_pkg::*;
(
    input  logic [31:0] raw,
    input  logic [1:0]  offset,
    input  logic [3:0]  op,
    output logic [31:0] result
);

    logic [31:0] shifted;

    always_comb begin
        shifted = raw >> {offset, 3'b000};
        case (op)
            LSU_LB:  result = {{24{shifted[7]}}, shifted[7:0]};
            LSU_LBU: result = {24'b0, shifted[7:0]};
            LSU_LH:  result = {{16{shifted[15]}}, shifted[15:0]};
            LSU_LHU: result = {16'b0, shifted[15:0]};
            default: result = shifted;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer between the MEM stage and the data bus: captures one
// op, checks alignment, runs the two-phase bus handshake and returns the result.
module lsu_ctrl
    import lsu_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_valid,
    input  logic [3:0]            mem_op,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [31:0]           mem_wdata,
    input  logic                  flush,
    output logic                  mem_ready,
    output logic [31:0]           mem_rdata,
    output logic                  mem_ale,
    output logic                  mem_stall,
    lsu_ctrl_if.master            bus
);

    lsu_state_e            state_q, state_d;
    logic [3:0]            op_q, op_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [31:0]           result_q, result_d;
    logic                  ale_q, ale_d;
    logic [31:0]           load_result;
    logic                  done_out;
    logic                  nop_ack;

    lsu_load_align u_load_align (
        .raw    (bus.data_rdata),
        .offset (addr_q[1:0]),
        .op     (op_q),
        .result (load_result)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            op_q     <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            result_q <= '0;
            ale_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            result_q <= result_d;
            ale_q    <= ale_d;
        end
    end

    // Flush takes precedence in every state except DRAIN, where a bus read
    // is still outstanding and must be absorbed before a new op can start.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        result_d = result_q;
        ale_d    = ale_q;
        case (state_q)
            ST_IDLE: begin
                if (mem_valid && !flush && !op_is_nop(mem_op)) begin
                    op_d     = mem_op;
                    addr_d   = mem_addr;
                    wdata_d  = mem_wdata;
                    result_d = '0;
                    if (op_misaligned(mem_op, mem_addr[1:0])) begin
                        ale_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        ale_d   = 1'b0;
                        state_d = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                if (flush) begin
                    state_d = bus.data_addr_ok ? ST_DRAIN : ST_IDLE;
                end else if (bus.data_addr_ok) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (flush) begin
                    state_d = bus.data_data_ok ? ST_IDLE : ST_DRAIN;
                end else if (bus.data_data_ok) begin
                    result_d = op_is_store(op_q) ? '0 : load_result;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            ST_DRAIN: begin
                if (bus.data_data_ok) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        done_out  = (state_q == ST_DONE) && !flush;
        nop_ack   = (state_q == ST_IDLE) && mem_valid && !flush && op_is_nop(mem_op);
        mem_ready = done_out || nop_ack;
        mem_rdata = done_out ? result_q : '0;
        mem_ale   = done_out && ale_q;
        mem_stall = mem_valid && !mem_ready;
    end

    // Bus fields come only from captured registers so they stay stable
    // for however long the address phase is held off.
    always_comb begin
        bus.data_req  = (state_q == ST_REQ);
        bus.data_wr   = op_is_store(op_q);
        bus.data_size = op_is_nop(op_q) ? SIZE_B : op_size(op_q);
        bus.data_addr = addr_q;
        case (op_q)
            LSU_SB: begin
                bus.data_wstrb = 4'b0001 << addr_q[1:0];
                bus.data_wdata = {4{wdata_q[7:0]}};
            end
            LSU_SH: begin
                bus.data_wstrb = 4'b0011 << addr_q[1:0];
                bus.data_wdata = {2{wdata_q[15:0]}};
            end
            LSU_SW: begin
                bus.data_wstrb = 4'hF;
                bus.data_wdata = wdata_q;
            end
            default: begin
                bus.data_wstrb = 4'h0;
                bus.data_wdata = wdata_q;
            end
        endcase
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: a transaction-level model predicts, per
// cycle, the pipeline and bus outputs for directed and random memory ops.
module tb_lsu_ctrl;
    import lsu_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid;
    logic [3:0]  mem_op;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        flush;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        mem_ale;
    logic        mem_stall;

    lsu_ctrl_if #(.ADDR_WIDTH(32)) bus ();

    lsu_ctrl #(.ADDR_WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_valid (mem_valid),
        .mem_op    (mem_op),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .flush     (flush),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .mem_ale   (mem_ale),
        .mem_stall (mem_stall),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    bit          chk_en = 1'b0;
    bit          exp_ready, exp_req, exp_ale, exp_wr;
    logic [31:0] exp_rdata, exp_addr, exp_wdata;
    logic [1:0]  exp_size;
    logic [3:0]  exp_strb;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, req, $time);
        end
    endtask

    // Model: ops described by access width in bytes and signedness.
    function automatic bit m_nop(input int op);
        return (op == 0) || (op > 8);
    endfunction

    function automatic bit m_store(input int op);
        return (op >= 6) && (op <= 8);
    endfunction

    function automatic int m_bytes(input int op);
        case (op)
            3, 4, 7: return 2;
            5, 8:    return 4;
            default: return 1;
        endcase
    endfunction

    function automatic bit m_misaligned(input int op, input logic [31:0] addr);
        return (addr % m_bytes(op)) != 0;
    endfunction

    function automatic logic [1:0] m_size(input int op);
        int b;
        b = m_bytes(op);
        return (b == 1) ? 2'd0 : (b == 2) ? 2'd1 : 2'd2;
    endfunction

    function automatic logic [3:0] m_strb(input int op, input logic [31:0] addr);
        logic [31:0] v;
        if (!m_store(op)) return 4'h0;
        v = ((32'd1 << m_bytes(op)) - 32'd1) << (addr % 4);
        return v[3:0];
    endfunction

    function automatic logic [31:0] m_wdata(input int op, input logic [31:0] w);
        case (m_bytes(op))
            1:       return (w & 32'hFF) * 32'h0101_0101;
            2:       return (w & 32'hFFFF) * 32'h0001_0001;
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] m_load(input int op, input logic [31:0] raw, input logic [31:0] addr);
        logic [31:0] mask, v;
        int b;
        b    = m_bytes(op);
        mask = (b == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * b)) - 32'd1);
        v    = (raw >> (8 * (addr % 4))) & mask;
        if ((op == 1 || op == 3) && v > (mask >> 1)) v = v | ~mask;
        return v;
    endfunction

    // Per-cycle comparison of DUT outputs against the model's expectations.
    always @(negedge clk) begin
        if (chk_en) begin
            checkOutput("mem_ready", 32'(mem_ready), 32'(exp_ready));
            checkOutput("mem_stall", 32'(mem_stall), 32'(mem_valid && !exp_ready));
            checkOutput("data_req", 32'(bus.data_req), 32'(exp_req));
            if (exp_ready) begin
                checkOutput("mem_rdata", mem_rdata, exp_rdata);
                checkOutput("mem_ale", 32'(mem_ale), 32'(exp_ale));
            end
            if (exp_req) begin
                checkOutput("data_wr", 32'(bus.data_wr), 32'(exp_wr));
                checkOutput("data_size", 32'(bus.data_size), 32'(exp_size));
                checkOutput("data_addr", bus.data_addr, exp_addr);
                checkOutput("data_wstrb", 32'(bus.data_wstrb), 32'(exp_strb));
                if (exp_wr) checkOutput("data_wdata", bus.data_wdata, exp_wdata);
            end
        end
    end

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            mem_valid            = 1'b0;
            flush                = 1'b0;
            bus.data_addr_ok     = 1'b0;
            bus.data_data_ok     = 1'b0;
            bus.data_rdata       = $urandom;
            exp_req              = 1'b0;
            exp_ready            = 1'b0;
            chk_en               = 1'b1;
            @(negedge clk);
            @(posedge clk);
            #1;
        end
    endtask

    // One op from the MEM stage plus the memory's responses, laid out on a
    // timeline relative to the accept cycle 0. flush_at < 0 means no flush.
    task automatic applyStimulus(input logic [3:0] op, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] rdata,
                                 input int ao_wait, input int do_wait, input int flush_at,
                                 input bit use_lit, input logic [31:0] lit_rdata,
                                 input bit use_lit_bus, input logic [3:0] lit_strb,
                                 input logic [31:0] lit_wdata);
        int  ao_cyc, do_cyc, ready_cyc, last;
        bit  nop, bad, ao_issued, killed, flushed_before;
        nop       = m_nop(int'(op));
        bad       = !nop && m_misaligned(int'(op), addr);
        ao_cyc    = 1 + ao_wait;
        do_cyc    = ao_cyc + 1 + do_wait;
        ready_cyc = nop ? 0 : bad ? 1 : do_cyc + 1;
        ao_issued = !nop && !bad && (flush_at < 0 || flush_at >= ao_cyc);
        killed    = (flush_at >= 0) && (flush_at <= ready_cyc);
        if (!killed) last = ready_cyc;
        else if (ao_issued) last = (do_cyc > flush_at) ? do_cyc : flush_at;
        else last = flush_at;

        exp_rdata = (nop || bad || m_store(int'(op))) ? 32'h0 : m_load(int'(op), rdata, addr);
        exp_ale   = bad;
        exp_wr    = m_store(int'(op));
        exp_size  = m_size(int'(op));
        exp_addr  = addr;
        exp_strb  = m_strb(int'(op), addr);
        exp_wdata = m_wdata(int'(op), wdata);

        for (int i = 0; i <= last; i++) begin
            flushed_before   = (flush_at >= 0) && (flush_at < i);
            mem_valid        = !flushed_before && (i <= ready_cyc);
            mem_op           = op;
            mem_addr         = addr;
            mem_wdata        = wdata;
            flush            = (i == flush_at);
            bus.data_addr_ok = ao_issued && (i == ao_cyc);
            bus.data_data_ok = ao_issued && (i == do_cyc);
            bus.data_rdata   = (ao_issued && i == do_cyc) ? rdata : $urandom;
            exp_req          = !nop && !bad && (i >= 1) && (i <= ao_cyc) && !flushed_before;
            exp_ready        = (i == ready_cyc) && !((flush_at >= 0) && (flush_at <= i));
            chk_en           = 1'b1;
            @(negedge clk);
            if (use_lit && i == ready_cyc) begin
                checkOutput("lit_ready", 32'(mem_ready), 32'd1);
                checkOutput("lit_rdata", mem_rdata, lit_rdata);
            end
            if (use_lit_bus && i == 1) begin
                checkOutput("lit_wstrb", 32'(bus.data_wstrb), 32'(lit_strb));
                checkOutput("lit_wdata", bus.data_wdata, lit_wdata);
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [3:0]  op;
        logic [31:0] addr;
        int          ao_w, do_w, f, rcyc;

        rst              = 1'b1;
        mem_valid        = 1'b0;
        mem_op           = 4'd0;
        mem_addr         = 32'd0;
        mem_wdata        = 32'd0;
        flush            = 1'b0;
        bus.data_addr_ok = 1'b0;
        bus.data_data_ok = 1'b0;
        bus.data_rdata   = 32'd0;
        exp_req          = 1'b0;
        exp_ready        = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_mem_ready", 32'(mem_ready), 32'd0);
        checkOutput("rst_mem_rdata", mem_rdata, 32'd0);
        checkOutput("rst_mem_ale", 32'(mem_ale), 32'd0);
        checkOutput("rst_mem_stall", 32'(mem_stall), 32'd0);
        checkOutput("rst_data_req", 32'(bus.data_req), 32'd0);
        checkOutput("rst_data_wr", 32'(bus.data_wr), 32'd0);
        checkOutput("rst_data_size", 32'(bus.data_size), 32'd0);
        checkOutput("rst_data_addr", bus.data_addr, 32'd0);
        checkOutput("rst_data_wstrb", 32'(bus.data_wstrb), 32'd0);
        checkOutput("rst_data_wdata", bus.data_wdata, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        $display("[TB] directed ops");
        applyStimulus(LSU_LB,  32'h103, 32'h0, 32'h80FF_1234, 0, 0, -1, 1'b1, 32'hFFFF_FF80, 1'b0, 4'h0, 32'h0);
        applyStimulus(LSU_LHU, 32'h102, 32'h0, 32'h8001_0000, 0, 0, -1, 1'b1, 32'h0000_8001, 1'b0, 4'h0, 32'h0);
        idleCycles(1);
        applyStimulus(LSU_LH,  32'h102, 32'h0, 32'h8001_0000, 1, 0, -1, 1'b1, 32'hFFFF_8001, 1'b0, 4'h0, 32'h0);
        applyStimulus(LSU_LW,  32'h100, 32'h0, 32'hCAFE_F00D, 0, 2, -1, 1'b1, 32'hCAFE_F00D, 1'b0, 4'h0, 32'h0);
        applyStimulus(LSU_SH,  32'h202, 32'hDEAD_BEEF, 32'h5555_AAAA, 1, 1, -1, 1'b1, 32'h0, 1'b1, 4'b1100, 32'hBEEF_BEEF);
        applyStimulus(LSU_LW,  32'h101, 32'h0, 32'h0, 0, 0, -1, 1'b1, 32'h0, 1'b0, 4'h0, 32'h0);
        applyStimulus(4'd12,   32'h40, 32'h0, 32'h0, 0, 0, -1, 1'b1, 32'h0, 1'b0, 4'h0, 32'h0);

        $display("[TB] directed flushes");
        applyStimulus(LSU_LW,  32'h300, 32'h0, 32'h0, 3, 0, 2, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        idleCycles(2);
        applyStimulus(LSU_LW,  32'h304, 32'h0, 32'h1234_5678, 0, 2, 2, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        applyStimulus(LSU_LW,  32'h308, 32'h0, 32'h0BAD_CAFE, 0, 0, -1, 1'b1, 32'h0BAD_CAFE, 1'b0, 4'h0, 32'h0);
        applyStimulus(LSU_LBU, 32'h30A, 32'h0, 32'h00C3_0000, 0, 0, 3, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        applyStimulus(LSU_SB,  32'h30B, 32'h0000_00A5, 32'h0, 0, 0, -1, 1'b1, 32'h0, 1'b1, 4'b1000, 32'hA5A5_A5A5);

        $display("[TB] reset mid-transaction");
        chk_en    = 1'b0;
        mem_valid = 1'b1;
        mem_op    = LSU_SW;
        mem_addr  = 32'h440;
        mem_wdata = 32'h1357_9BDF;
        @(posedge clk);
        #1 mem_valid = 1'b0;
        @(negedge clk);
        checkOutput("pre_rst_data_req", 32'(bus.data_req), 32'd1);
        #1 rst = 1'b1;
        #1;
        checkOutput("mid_rst_data_req", 32'(bus.data_req), 32'd0);
        checkOutput("mid_rst_data_addr", bus.data_addr, 32'd0);
        checkOutput("mid_rst_data_wstrb", 32'(bus.data_wstrb), 32'd0);
        checkOutput("mid_rst_mem_ready", 32'(mem_ready), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        applyStimulus(LSU_LW, 32'h444, 32'h0, 32'h2468_ACE0, 0, 0, -1, 1'b1, 32'h2468_ACE0, 1'b0, 4'h0, 32'h0);

        $display("[TB] random ops");
        for (int n = 0; n < 300; n++) begin
            op   = 4'($urandom_range(0, 15));
            addr = $urandom;
            if ($urandom_range(0, 4) < 3) addr = addr - (addr % m_bytes(int'(op)));
            ao_w = $urandom_range(0, 3);
            do_w = $urandom_range(0, 3);
            rcyc = m_misaligned(int'(op), addr) ? 1 : ao_w + do_w + 3;
            f    = -1;
            if (!m_nop(int'(op)) && $urandom_range(0, 4) == 0) f = $urandom_range(0, rcyc);
            applyStimulus(op, addr, $urandom, $urandom, ao_w, do_w, f, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
            idleCycles($urandom_range(0, 2));
        end

        chk_en = 1'b0;
        @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
